// File: rtl/pc_ras.sv
// Program counter with relative branches, call/return and a circular return-address stack.
// Optional define PC_ALIGN_CHECK_EN adds the misalign output and suppresses misaligned redirects.
module pc_ras #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter int unsigned           INCR       = 4,
    parameter int unsigned           RAS_DEPTH  = 8
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             enable,
    input  logic                             jump_signal,
    input  logic                             branch_signal,
    input  logic [DATA_WIDTH-1:0]            branch_address,
    input  logic [DATA_WIDTH-1:0]            branch_offset,
    input  logic                             call_signal,
    input  logic                             ret_signal,
`ifdef PC_ALIGN_CHECK_EN
    output logic                             misalign,
`endif
    output logic [DATA_WIDTH-1:0]            PCOut,
    output logic [DATA_WIDTH-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_full,
    output logic                             ras_empty,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] INCR_W = DATA_WIDTH'(INCR);
    // INCR=1 gives an all-zero mask, which disables the alignment check.
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(INCR - 1);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]         sp_q, sp_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] stack_q [RAS_DEPTH];

    logic [DATA_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] target;
    logic                  take_ret, fall_through, take_call, take_jump, take_branch;
    logic                  redirect;
    logic                  bad_align;
    logic                  push_en;

    assign pc_inc    = pc_q + INCR_W;
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == CW'(RAS_DEPTH));
    // sp_q points at the next free slot, so the newest entry sits just below it.
    assign ras_top   = ras_empty ? '0 : stack_q[sp_q - PW'(1)];

    assign PCOut         = pc_q;
    assign ras_count     = count_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

    always_comb begin
        take_ret     = ret_signal && !ras_empty;
        fall_through = ret_signal && ras_empty;
        take_call    = !ret_signal && call_signal;
        take_jump    = !ret_signal && !call_signal && jump_signal;
        take_branch  = !ret_signal && !call_signal && !jump_signal && branch_signal;
        redirect     = take_ret || take_call || take_jump || take_branch;

        if (take_ret) begin
            target = ras_top;
        end else if (take_call || take_jump) begin
            target = branch_address;
        end else begin
            target = pc_q + branch_offset;
        end

`ifdef PC_ALIGN_CHECK_EN
        bad_align = redirect && ((target & ALIGN_MASK) != '0);
`else
        bad_align = 1'b0;
`endif
    end

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (enable) begin
            if (fall_through) begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end else if (!redirect) begin
                pc_d = pc_inc;
            end else if (!bad_align) begin
                pc_d = target;
                if (take_ret) begin
                    sp_d    = sp_q - PW'(1);
                    count_d = count_q - CW'(1);
                end else if (take_call) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + PW'(1);
                    if (ras_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            pc_q    <= INIT;
            sp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries are never reset; they are hidden by ras_count while the stack is empty.
    always_ff @(posedge clock) begin
        if (push_en && !clear) begin
            stack_q[sp_q] <= pc_inc;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= enable && bad_align;
        end
    end

    assign misalign = misalign_q;
`endif

endmodule
